embedded_system_led_pwm: RTL and testbench



---
 rtl/embedded_system_led_pkg.sv | 17 +
 rtl/embedded_system_led_timebase.sv | 35 +++
 rtl/embedded_system_led_pwm.sv | 150 +++++++++++++++
 tb/tb_embedded_system_led_pwm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/embedded_system_led_pkg.sv
// Shared constants for the LED PWM controller.
//   ADDR_*           : Avalon word addresses of the register map
//   BLINK_CNT_W      : width of BLINK_PERIOD and the blink counter
//   STATUS_PHASE_BIT : readdata bit position of the blink phase in STATUS
package embedded_system_led_pkg;
  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_SET          = 3'd1;
  localparam logic [2:0] ADDR_CLEAR        = 3'd2;
  localparam logic [2:0] ADDR_MODE         = 3'd3;
  localparam logic [2:0] ADDR_DUTY         = 3'd4;
  localparam logic [2:0] ADDR_BLINK        = 3'd5;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd6;
  localparam logic [2:0] ADDR_STATUS       = 3'd7;

  localparam int BLINK_CNT_W      = 16;
  localparam int STATUS_PHASE_BIT = 16;
endpackage

// File: rtl/embedded_system_led_timebase.sv
// PWM timebase: prescaler plus PWM period counter.
//   clk, reset_n : clock, async active-low reset
//   pwm_cnt      : position inside the PWM period, 0 .. 2^PWM_BITS-1
//   tick         : high for the one clk cycle that ends a prescaler interval
//   wrap         : high on the tick where pwm_cnt rolls from all-ones to 0
module embedded_system_led_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                wrap
);
  // PRESCALE=1 still needs a 1-bit counter; it simply stays at 0.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]     r_prescale;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  assign tick    = (r_prescale == PS_W'(PRESCALE - 1));
  assign wrap    = tick && (r_pwm_cnt == '1);
  assign pwm_cnt = r_pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_pwm_cnt  <= '0;
    end else begin
      r_prescale <= tick ? '0 : r_prescale + PS_W'(1);
      if (tick) r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end
endmodule

// File: rtl/embedded_system_led_pwm.sv
// Avalon-MM LED output controller: static data with atomic set/clear,
// per-channel PWM dimming and (optionally) per-channel blink.
// Build option: define EMBEDDED_SYSTEM_LED_PWM_BLINK_EN to implement the
// BLINK / BLINK_PERIOD registers; otherwise they read 0 and phase is 1.
//   clk, reset_n     : clock, async active-low reset
//   address          : word address (see embedded_system_led_pkg)
//   chipselect       : slave select
//   write_n          : active-low write strobe
//   writedata        : write data
//   readdata         : combinational read data, zero wait states
//   out_port         : registered LED drive
module embedded_system_led_pwm
  import embedded_system_led_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic                w_wr;
  logic [WIDTH-1:0]    w_wd;
  logic [PWM_BITS-1:0] w_pwm_cnt;
  logic                w_tick;
  logic                w_wrap;
  logic                w_pwm_on;
  logic                w_phase;
  logic [WIDTH-1:0]    w_pwm_mask;
  logic [WIDTH-1:0]    w_blink_mask;
  logic                w_unused;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_mode;
  logic [PWM_BITS-1:0] r_duty_pend;
  logic [PWM_BITS-1:0] r_duty_act;
  logic [WIDTH-1:0]    r_out;

  assign w_wr     = chipselect && !write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_unused = ^{writedata, w_tick};

  embedded_system_led_timebase #(
    .PWM_BITS(PWM_BITS),
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk     (clk),
    .reset_n (reset_n),
    .pwm_cnt (w_pwm_cnt),
    .tick    (w_tick),
    .wrap    (w_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= '0;
      r_mode      <= '0;
      r_duty_pend <= '0;
      r_duty_act  <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          ADDR_DATA:  r_data      <= w_wd;
          ADDR_SET:   r_data      <= r_data | w_wd;
          ADDR_CLEAR: r_data      <= r_data & ~w_wd;
          ADDR_MODE:  r_mode      <= w_wd;
          ADDR_DUTY:  r_duty_pend <= writedata[PWM_BITS-1:0];
          default: ;
        endcase
      end
      // Pending duty only lands on a period boundary; a DUTY write on the
      // same edge is picked up at the following wrap.
      if (w_wrap) r_duty_act <= r_duty_pend;
    end
  end

`ifdef EMBEDDED_SYSTEM_LED_PWM_BLINK_EN
  logic [WIDTH-1:0]       r_blink;
  logic [BLINK_CNT_W-1:0] r_blink_period;
  logic [BLINK_CNT_W-1:0] r_blink_cnt;
  logic                   r_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink        <= '0;
      r_blink_period <= '0;
      r_blink_cnt    <= '0;
      r_phase        <= 1'b1;
    end else begin
      if (w_wr && address == ADDR_BLINK) r_blink <= w_wd;
      // A new period restarts the count but leaves the phase alone.
      if (w_wr && address == ADDR_BLINK_PERIOD) begin
        r_blink_period <= writedata[BLINK_CNT_W-1:0];
        r_blink_cnt    <= '0;
      end else if (r_blink_period == '0) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b1;
      end else if (w_wrap) begin
        if (r_blink_cnt == r_blink_period - BLINK_CNT_W'(1)) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLINK_CNT_W'(1);
        end
      end
    end
  end

  assign w_phase      = r_phase;
  assign w_blink_mask = r_phase ? '1 : ~r_blink;
`else
  assign w_phase      = 1'b1;
  assign w_blink_mask = '1;
`endif

  // Channels not in PWM mode pass straight through the PWM mask.
  assign w_pwm_on   = (w_pwm_cnt < r_duty_act);
  assign w_pwm_mask = w_pwm_on ? '1 : ~r_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_out <= '0;
    else          r_out <= r_data & w_pwm_mask & w_blink_mask;
  end

  assign out_port = r_out;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:         readdata[WIDTH-1:0]    = r_data;
      ADDR_MODE:         readdata[WIDTH-1:0]    = r_mode;
      ADDR_DUTY:         readdata[PWM_BITS-1:0] = r_duty_pend;
`ifdef EMBEDDED_SYSTEM_LED_PWM_BLINK_EN
      ADDR_BLINK:        readdata[WIDTH-1:0]       = r_blink;
      ADDR_BLINK_PERIOD: readdata[BLINK_CNT_W-1:0] = r_blink_period;
`endif
      ADDR_STATUS: begin
        readdata[PWM_BITS-1:0]     = w_pwm_cnt;
        readdata[STATUS_PHASE_BIT] = w_phase;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_embedded_system_led_pwm.sv
// Self-checking bench for embedded_system_led_pwm (WIDTH=10, PWM_BITS=4,
// PRESCALE=1): directed table, PWM/blink/reset sequences and random traffic
// against a period-arithmetic reference model.
module tb_embedded_system_led_pwm;
  localparam int W   = 10;
  localparam int PB  = 4;
  localparam int PER = 16;
`ifdef EMBEDDED_SYSTEM_LED_PWM_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;

  int checks = 0;
  int errors = 0;

  embedded_system_led_pwm #(.WIDTH(W), .PWM_BITS(PB), .PRESCALE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Reference model: with PRESCALE=1 the PWM counter is simply the number of
  // clock edges since reset release, modulo the period.
  logic [W-1:0] m_data, m_mode, m_blink, m_out;
  int           m_pend, m_act, m_bp, m_bcnt, m_cyc;
  logic         m_phase;

  task automatic model_reset();
    m_data = '0; m_mode = '0; m_blink = '0; m_out = '0;
    m_pend = 0; m_act = 0; m_bp = 0; m_bcnt = 0; m_cyc = 0; m_phase = 1'b1;
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0] = m_data;
      3'd3: r[W-1:0] = m_mode;
      3'd4: r = 32'(m_pend);
      3'd5: if (BLINK_EN) r[W-1:0] = m_blink;
      3'd6: if (BLINK_EN) r = 32'(m_bp);
      3'd7: begin r = 32'(m_cyc % PER); r[16] = m_phase; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_edge(input logic wr, input logic [2:0] a, input logic [31:0] wd);
    int c;
    logic [W-1:0] pm, bm;
    c  = m_cyc % PER;
    pm = (c < m_act) ? '1 : ~m_mode;
    bm = m_phase ? '1 : ~m_blink;
    m_out = m_data & pm & bm;
    if (c == PER - 1) m_act = m_pend;
    if (BLINK_EN) begin
      if (wr && a == 3'd6) m_bcnt = 0;
      else if (m_bp == 0) begin m_bcnt = 0; m_phase = 1'b1; end
      else if (c == PER - 1) begin
        m_bcnt++;
        if (m_bcnt == m_bp) begin m_bcnt = 0; m_phase = ~m_phase; end
      end
    end
    if (wr) begin
      case (a)
        3'd0: m_data = wd[W-1:0];
        3'd1: m_data = m_data | wd[W-1:0];
        3'd2: m_data = m_data & ~wd[W-1:0];
        3'd3: m_mode = wd[W-1:0];
        3'd4: m_pend = int'(wd[PB-1:0]);
        3'd5: if (BLINK_EN) m_blink = wd[W-1:0];
        3'd6: if (BLINK_EN) m_bp = int'(wd[15:0]);
        default: ;
      endcase
    end
    m_cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One bus cycle, entered and left on a negedge. Checks readdata before the
  // edge and out_port after it against the model.
  task automatic cycle(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd, output logic [31:0] rd_s,
                       output logic [W-1:0] out_s);
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    #1;
    rd_s = readdata;
    chk("rd", readdata, model_rd(a));
    @(posedge clk);
    model_edge(cs && !wn, a, wd);
    @(negedge clk);
    out_s = out_port;
    chk("out", 32'(out_port), 32'(m_out));
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0]  rd;
    logic [W-1:0] o;
    int           hi;
    int           chg[$];

    tbl[0] = '{1'b1, 1'b0, 3'd0, 32'h3FF, 32'h000, 10'h000};
    tbl[1] = '{1'b1, 1'b0, 3'd2, 32'h00F, 32'h000, 10'h3FF};
    tbl[2] = '{1'b0, 1'b1, 3'd0, 32'h000, 32'h3F0, 10'h3F0};
    tbl[3] = '{1'b1, 1'b0, 3'd1, 32'h001, 32'h000, 10'h3F0};
    tbl[4] = '{1'b0, 1'b1, 3'd0, 32'h000, 32'h3F1, 10'h3F1};
    tbl[5] = '{1'b1, 1'b1, 3'd4, 32'h000, 32'h000, 10'h3F1};
    tbl[6] = '{1'b1, 1'b0, 3'd7, 32'hFFFF, 32'h10006, 10'h3F1};

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_out", 32'(out_port), 32'h0);
    address = 3'd7; #1;
    chk("reset_status", readdata, 32'h0001_0000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].cs, tbl[i].wn, tbl[i].a, tbl[i].wd, rd, o);
      chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_out", i), 32'(o), 32'(tbl[i].exp_out));
    end

    // PWM channel 0 at duty 4: dark until the next wrap, then 4/16.
    cycle(1, 0, 3'd3, 32'h001, rd, o);
    cycle(1, 0, 3'd0, 32'h001, rd, o);
    cycle(1, 0, 3'd4, 32'd4, rd, o);
    hi = 0;
    for (int k = 0; k < 64 && (m_cyc % PER) != 0; k++) begin
      cycle(0, 1, 3'd4, 0, rd, o); hi += int'(o[0]);
    end
    chk("pre_wrap_low", 32'(hi), 0);
    hi = 0;
    for (int k = 0; k < PER; k++) begin cycle(0, 1, 3'd7, 0, rd, o); hi += int'(o[0]); end
    chk("duty4_high", 32'(hi), 4);
    // Mid-period DUTY change must not disturb the running period.
    hi = 0;
    for (int k = 0; k < 5; k++) begin cycle(0, 1, 3'd7, 0, rd, o); hi += int'(o[0]); end
    cycle(1, 0, 3'd4, 32'd12, rd, o); hi += int'(o[0]);
    for (int k = 0; k < 10; k++) begin cycle(0, 1, 3'd7, 0, rd, o); hi += int'(o[0]); end
    chk("midwrite_keep4", 32'(hi), 4);
    hi = 0;
    for (int k = 0; k < PER; k++) begin cycle(0, 1, 3'd7, 0, rd, o); hi += int'(o[0]); end
    chk("duty12_high", 32'(hi), 12);

`ifdef EMBEDDED_SYSTEM_LED_PWM_BLINK_EN
    cycle(1, 0, 3'd3, 32'h000, rd, o);
    cycle(1, 0, 3'd5, 32'h002, rd, o);
    cycle(1, 0, 3'd0, 32'h002, rd, o);
    cycle(1, 0, 3'd6, 32'd3, rd, o);
    for (int k = 0; k < 170; k++) begin
      logic prev;
      prev = o[1];
      cycle(0, 1, 3'd7, 0, rd, o);
      if (o[1] != prev) chg.push_back(k);
    end
    chk("blink_toggles", 32'(chg.size() >= 3), 1);
    for (int k = 1; k < chg.size(); k++)
      chk($sformatf("blink_gap%0d", k), 32'(chg[k] - chg[k-1]), 48);
    cycle(1, 0, 3'd6, 32'd0, rd, o);
    cycle(0, 1, 3'd7, 0, rd, o);
    cycle(0, 1, 3'd7, 0, rd, o);
    hi = 0;
    for (int k = 0; k < 40; k++) begin cycle(0, 1, 3'd7, 0, rd, o); hi += int'(o[1]); end
    chk("bp0_hold_high", 32'(hi), 40);
`else
    cycle(1, 0, 3'd0, 32'h3FF, rd, o);
    cycle(1, 0, 3'd5, 32'h3FF, rd, o);
    cycle(1, 1, 3'd5, 32'h0, rd, o);
    chk("addr5_rd_zero", rd, 32'h0);
    cycle(1, 0, 3'd6, 32'h3, rd, o);
    cycle(1, 1, 3'd6, 32'h0, rd, o);
    chk("addr6_rd_zero", rd, 32'h0);
    cycle(1, 1, 3'd7, 32'h0, rd, o);
    chk("status_phase1", 32'(rd[16]), 1);
    chk("addr5_out_kept", 32'(o), 32'h3FF);
`endif

    // Random traffic; blink periods kept short so phases actually move.
    for (int k = 0; k < 600; k++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd6) wd = 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, wd, rd, o);
    end

    // Reset mid-period with everything lit.
    cycle(1, 0, 3'd0, 32'h3FF, rd, o);
    cycle(1, 0, 3'd3, 32'h000, rd, o);
    cycle(1, 0, 3'd5, 32'h000, rd, o);
    repeat (5) cycle(0, 1, 3'd0, 0, rd, o);
    chk("pre_reset_on", 32'(out_port), 32'h3FF);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_out", 32'(out_port), 32'h0);
    address = 3'd7; #1;
    chk("in_reset_status", readdata, 32'h0001_0000);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1 chk("post_reset_status", readdata, 32'h0001_0000);
    @(negedge clk);
    model_edge(1'b0, 3'd7, 0);
    chk("post_reset_out", 32'(out_port), 32'h0);
    repeat (20) cycle(0, 1, 3'd7, 0, rd, o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
